irq_controller: RTL

//  Parametrised multi-source interrupt controller on the data-memory/IO bus. Replaces the single

---
 rtl/irq_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Multi-source vectored interrupt controller on the IO bus.
//                Synchronises request lines, latches edge/level pending bits,
//                picks the lowest-index enabled source and presents it to the
//                CPU with an interrupt/intVect/intAck handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_controller #(
   parameter int          NUM_SRC     = 8,
   parameter logic [15:0] BASE_ADDR   = 16'h1010,
   parameter logic [15:0] VECT_BASE   = 16'h0008,
   parameter int          VECT_STRIDE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        address,
   input  logic [7:0]         din,
   input  logic               w_en,
   input  logic               r_en,
   output logic [7:0]         dout,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               interrupt,
   output logic [15:0]        intVect,
   input  logic               intAck
);

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_REQ  = 1'b1;

   localparam logic [2:0] c_REG_EN     = 3'd0;
   localparam logic [2:0] c_REG_PEND   = 3'd1;
   localparam logic [2:0] c_REG_MODE   = 3'd2;
   localparam logic [2:0] c_REG_POL    = 3'd3;
   localparam logic [2:0] c_REG_STATUS = 3'd4;

   logic [NUM_SRC-1:0] r_sync1, r_sync2, r_s_d;
   logic [NUM_SRC-1:0] r_enable, r_mode, r_pol, r_pend_edge;
   logic [NUM_SRC-1:0] w_s, w_edge, w_pend, w_cand, w_w1c, w_ack_clr;
   logic [0:0]         r_state;
   logic [2:0]         r_idx, w_win, w_reg;
   logic [15:0]        w_offs, w_vect;
   logic               w_sel, w_ack;
   logic [7:0]         w_cand8, w_idx_oh, w_rdata;

   // Bus decode: offset relative to BASE_ADDR, five registers wide
   always_comb begin
      w_offs = address - BASE_ADDR;
      w_sel  = (w_offs <= 16'd4);
      w_reg  = w_offs[2:0];
   end

   // Synchronised, polarity-corrected request level and its rising edge
   always_comb begin
      w_s    = r_sync2 ^ r_pol;
      w_edge = w_s & ~r_s_d;
      // Level-mode bits follow the line directly; edge-mode bits come from the latch
      w_pend = (r_mode & r_pend_edge) | (~r_mode & w_s);
      w_cand = w_pend & r_enable;
   end

   // Zero-extended views so a 3-bit index is always in range
   always_comb begin
      w_cand8                = '0;
      w_cand8[NUM_SRC-1:0]   = w_cand;
      w_idx_oh               = 8'd1 << r_idx;
      w_ack                  = (r_state == c_ST_REQ) && intAck;
      w_ack_clr              = w_ack ? w_idx_oh[NUM_SRC-1:0] : '0;
      w_w1c                  = (w_en && w_sel && (w_reg == c_REG_PEND)) ? din[NUM_SRC-1:0] : '0;
   end

   // Fixed priority: lowest set index wins
   always_comb begin
      w_win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_cand[i]) w_win = 3'(i);
      end
      w_vect = VECT_BASE + ({13'd0, w_win} * 16'(VECT_STRIDE));
   end

   // Two-flop synchroniser plus delayed copy for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_s_d   <= '0;
      end else begin
         r_sync1 <= irq_src;
         r_sync2 <= r_sync1;
         r_s_d   <= w_s;
      end
   end

   // Writable configuration registers; bits above NUM_SRC are never stored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enable <= '0;
         r_mode   <= '0;
         r_pol    <= '0;
      end else if (w_en && w_sel) begin
         case (w_reg)
            c_REG_EN:   r_enable <= din[NUM_SRC-1:0];
            c_REG_MODE: r_mode   <= din[NUM_SRC-1:0];
            c_REG_POL:  r_pol    <= din[NUM_SRC-1:0];
            default:    ;
         endcase
      end
   end

   // Edge latch: a new edge beats W1C/ack; leaving edge mode drops the latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_edge <= '0;
      end else begin
         r_pend_edge <= r_mode & (w_edge | (r_pend_edge & ~w_w1c & ~w_ack_clr));
      end
   end

   // Request FSM: present one source, hold it until ack or retraction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_ST_IDLE;
         r_idx     <= '0;
         interrupt <= 1'b0;
         intVect   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (|w_cand) begin
                  r_state   <= c_ST_REQ;
                  r_idx     <= w_win;
                  interrupt <= 1'b1;
                  intVect   <= w_vect;
               end
            end
            default: begin
               if (intAck || !w_cand8[r_idx]) begin
                  r_state   <= c_ST_IDLE;
                  interrupt <= 1'b0;
                  intVect   <= '0;
               end
            end
         endcase
      end
   end

   // Read mux, zero-extended to the byte bus
   always_comb begin
      w_rdata = '0;
      case (w_reg)
         c_REG_EN:     w_rdata[NUM_SRC-1:0] = r_enable;
         c_REG_PEND:   w_rdata[NUM_SRC-1:0] = w_pend;
         c_REG_MODE:   w_rdata[NUM_SRC-1:0] = r_mode;
         c_REG_POL:    w_rdata[NUM_SRC-1:0] = r_pol;
         c_REG_STATUS: w_rdata = {(r_state == c_ST_REQ), 4'd0, r_idx};
         default:      w_rdata = '0;
      endcase
   end

   // Registered read data, one cycle after r_en like the RAM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (r_en && w_sel) begin
         dout <= w_rdata;
      end else begin
         dout <= '0;
      end
   end

endmodule
`default_nettype wire
